top_systolic_array: RTL and testbench

//  NxN output-stationary systolic matrix multiplier, C = A x B, on signed Q4.4 (8-bit) operands.

---
 rtl/systolic_pkg.sv | 44 ++++
 rtl/systolic_array_pe.sv | 45 ++++
 rtl/top_systolic_array.sv | 185 ++++++++++++++++++
 tb/tb_top_systolic_array.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic multiplier.
//
// Contents:
//   q4_4_t      signed 8-bit operand / result (4 integer, 4 fraction bits)
//   prod_t      signed 16-bit product of two Q4.4 values (Q8.8)
//   state_t     controller states: idle, streaming operands, publishing result
//   FRAC_BITS   fraction bits of the Q4.4 format
//   acc_w()     accumulator width that holds N Q8.8 products without overflow
//   sat_q4_4()  rescale an accumulator to Q4.4, rounding toward -inf, saturating
package systolic_pkg;

    typedef logic signed [7:0]  q4_4_t;
    typedef logic signed [15:0] prod_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int FRAC_BITS = 4;

    // One guard bit beyond log2(N) keeps the sum of N full-scale products
    // exact, including the most negative corner.
    function automatic int acc_w(input int n);
        return 16 + $clog2(n) + 1;
    endfunction

    // The accumulator arrives sign-extended to 32 bits. The arithmetic shift
    // drops the extra fraction bits with floor semantics; the clamp then maps
    // anything outside the 8-bit range onto the nearest representable value.
    function automatic q4_4_t sat_q4_4(input logic signed [31:0] acc);
        logic signed [31:0] shifted;
        shifted = acc >>> FRAC_BITS;
        if (shifted > 32'sd127) begin
            return 8'sh7F;
        end else if (shifted < -32'sd128) begin
            return 8'sh80;
        end else begin
            return q4_4_t'(shifted[7:0]);
        end
    endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// One processing element of the output-stationary grid.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   a_in, b_in     operands arriving from the left / top neighbour (Q4.4)
//   clr            start of a new job: zero accumulator and forwarding registers
//   en             job is streaming: accumulate and forward operands
//   a_out, b_out   registered copies of a_in / b_in for the right / lower neighbour
//   acc            running sum of a_in*b_in in Q8.8, ACC_W bits signed
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    input  q4_4_t                   a_in,
    input  q4_4_t                   b_in,
    input  logic                    clr,
    input  logic                    en,
    output q4_4_t                   a_out,
    output q4_4_t                   b_out,
    output logic signed [ACC_W-1:0] acc
);

    prod_t prod;

    assign prod = a_in * b_in;

    // Operands move one hop per cycle while the job streams. Idle slots carry
    // zeros, so accumulating on every enabled cycle adds nothing outside the
    // slots that hold real matrix elements.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/top_systolic_array.sv
// NxN output-stationary systolic matrix multiplier, C = A x B, signed Q4.4.
//
// Ports:
//   i_clk          clock, all logic on the rising edge
//   i_arst         synchronous active-high reset
//   i_a            matrix A, A(i,k) = i_a[i][k]
//   i_b            matrix B, B(k,j) = i_b[k][j]
//   i_validInput   start pulse; i_a / i_b captured on the same edge (from idle only)
//   o_c            result C(i,j) = o_c[i][j], held until the next result or reset
//   o_validResult  one-cycle pulse marking a fresh o_c
module top_systolic_array
    import systolic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic [N-1:0][N-1:0][7:0]     i_a,
    input  logic [N-1:0][N-1:0][7:0]     i_b,
    input  logic                         i_validInput,
    output logic [N-1:0][N-1:0][7:0]     o_c,
    output logic                         o_validResult
);

    localparam int ACC_W = acc_w(N);
    localparam int SKEW  = 2 * N - 1;
    localparam int CNT_W = $clog2(3 * N);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;
    logic              start;
    logic              run_en;
    logic              publish;

    logic [7:0] a_skew [N][SKEW];
    logic [7:0] b_skew [N][SKEW];

    q4_4_t                   a_pe   [N][N];
    q4_4_t                   b_pe   [N][N];
    q4_4_t                   a_fwd  [N][N];
    q4_4_t                   b_fwd  [N][N];
    logic signed [ACC_W-1:0] acc_grid [N][N];
    logic                    unused_edge_data;

    // State register and run counter. The counter restarts on the accepting
    // edge so that counter value c is the c-th streaming cycle of the job.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                count_q <= '0;
            end else if (run_en) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic. Start requests are only honoured from idle, so a job
    // in flight can never be disturbed and nothing is queued.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        run_en  = 1'b0;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_validInput) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_en = 1'b1;
                if (count_q == CNT_W'(3 * N - 2)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                publish = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Skew lines double as the input buffers. On the accepting edge row i of A
    // is laid out starting at slot i, with zeros around it; column j of B
    // likewise at slot j. Each streaming cycle shifts one slot toward slot 0,
    // which feeds the grid edge, so A(i,k) reaches PE(i,0) at counter i+k and
    // B(k,j) reaches PE(0,j) at counter j+k.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            for (int r = 0; r < N; r++) begin
                for (int m = 0; m < SKEW; m++) begin
                    a_skew[r][m] <= '0;
                    b_skew[r][m] <= '0;
                end
            end
        end else if (start) begin
            for (int r = 0; r < N; r++) begin
                for (int m = 0; m < SKEW; m++) begin
                    a_skew[r][m] <= '0;
                    b_skew[r][m] <= '0;
                end
                for (int k = 0; k < N; k++) begin
                    a_skew[r][r + k] <= i_a[r][k];
                    b_skew[r][r + k] <= i_b[k][r];
                end
            end
        end else if (run_en) begin
            for (int r = 0; r < N; r++) begin
                for (int m = 0; m < SKEW - 1; m++) begin
                    a_skew[r][m] <= a_skew[r][m + 1];
                    b_skew[r][m] <= b_skew[r][m + 1];
                end
                a_skew[r][SKEW - 1] <= '0;
                b_skew[r][SKEW - 1] <= '0;
            end
        end
    end

    // PE grid: A flows rightward, B flows downward, one register per hop.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_pe[i][j] = a_skew[i][0];
            end else begin : g_a_link
                assign a_pe[i][j] = a_fwd[i][j - 1];
            end
            if (i == 0) begin : g_b_edge
                assign b_pe[i][j] = b_skew[j][0];
            end else begin : g_b_link
                assign b_pe[i][j] = b_fwd[i - 1][j];
            end

            systolic_pe #(
                .ACC_W (ACC_W)
            ) u_pe (
                .clock (i_clk),
                .reset (i_arst),
                .a_in  (a_pe[i][j]),
                .b_in  (b_pe[i][j]),
                .clr   (start),
                .en    (run_en),
                .a_out (a_fwd[i][j]),
                .b_out (b_fwd[i][j]),
                .acc   (acc_grid[i][j])
            );
        end
    end

    // The right column's A outputs and bottom row's B outputs leave the grid
    // and are intentionally discarded.
    always_comb begin
        unused_edge_data = 1'b0;
        for (int r = 0; r < N; r++) begin
            unused_edge_data = unused_edge_data ^ (^a_fwd[r][N - 1]) ^ (^b_fwd[N - 1][r]);
        end
    end

    // Result register: rescaled, saturated results are captured once per job
    // and then held, so o_c stays stable between pulses.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_c           <= '0;
            o_validResult <= 1'b0;
        end else begin
            o_validResult <= publish;
            if (publish) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        o_c[r][c] <= sat_q4_4(32'(acc_grid[r][c]));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_top_systolic_array.sv
// Self-checking bench for top_systolic_array (N = 4).
module tb_top_systolic_array;

    localparam int N = 4;

    typedef logic [N-1:0][N-1:0][7:0] mat_t;

    typedef struct {
        string name;
        mat_t  a;
        mat_t  b;
        mat_t  exp_c;
    } vector_t;

    logic i_clk;
    logic i_arst;
    logic i_validInput;
    mat_t i_a;
    mat_t i_b;
    mat_t o_c;
    logic o_validResult;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    mat_t exp_q[$];
    int   exp_cyc_q[$];
    mat_t last_c = '0;
    vector_t vecs[$];

    top_systolic_array #(
        .N (N)
    ) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_validInput  (i_validInput),
        .o_c           (o_c),
        .o_validResult (o_validResult)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Edge counter: at a falling edge it equals the number of rising edges seen.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
    end

    // Bit-exact reference: integer dot products, floor shift, clamp.
    function automatic mat_t model(input mat_t a, input mat_t b);
        mat_t c;
        int   acc;
        int   x;
        int   y;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    x = $signed(a[i][k]);
                    y = $signed(b[k][j]);
                    acc += x * y;
                end
                acc = acc >>> 4;
                if (acc > 127) acc = 127;
                if (acc < -128) acc = -128;
                c[i][j] = 8'(acc);
            end
        end
        return c;
    endfunction

    function automatic mat_t fill(input logic [7:0] v);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic checkEqual(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding job
    // in both data and arrival cycle; a pulse with nothing outstanding is an error.
    always @(negedge i_clk) begin
        if (!i_arst && o_validResult !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: got valid=%b at cycle %0d expected no pulse",
                         o_validResult, cyc);
            end else begin
                mat_t e;
                int   ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                last_c = e;
                checks++;
                if (o_c !== e) begin
                    errors++;
                    $display("[TB] FAIL result_data: got %h expected %h", o_c, e);
                end
                if (cyc != ec) begin
                    errors++;
                    $display("[TB] FAIL result_latency: got cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end
    end

    // Launch one job from a falling edge and register its expected result.
    task automatic applyStimulus(input mat_t a, input mat_t b, input mat_t exp_c);
        @(negedge i_clk);
        i_a          = a;
        i_b          = b;
        i_validInput = 1'b1;
        exp_q.push_back(exp_c);
        exp_cyc_q.push_back(cyc + 1 + 3 * N);
        @(negedge i_clk);
        i_validInput = 1'b0;
    endtask

    // Wait (bounded) for all outstanding results, then confirm o_c holds.
    task automatic checkOutput(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 6 * N + 8) begin
            @(negedge i_clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d results pending expected 0", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge i_clk);
        checkEqual({name, "_hold"}, 128'(o_c), 128'(last_c));
    endtask

    initial begin
        mat_t a;
        mat_t b;
        mat_t a2;
        vector_t v;

        i_arst       = 1'b1;
        i_validInput = 1'b0;
        i_a          = '0;
        i_b          = '0;
        repeat (3) @(negedge i_clk);
        i_arst = 1'b0;
        checkEqual("reset_o_c", 128'(o_c), 128'(0));
        checkEqual("reset_valid", 128'(o_validResult), 128'(0));

        // Stimulus table.
        a = '0;
        for (int i = 0; i < N; i++) a[i][i] = 8'h10;
        b = rand_mat();
        v = '{name: "identity", a: a, b: b, exp_c: b};                       vecs.push_back(v);
        v = '{name: "ones", a: fill(8'h10), b: fill(8'h10), exp_c: fill(8'h40)}; vecs.push_back(v);
        v = '{name: "neg_ones", a: fill(8'hF0), b: fill(8'h10), exp_c: fill(8'hC0)}; vecs.push_back(v);
        v = '{name: "sat_pos", a: fill(8'h20), b: fill(8'h20), exp_c: fill(8'h7F)}; vecs.push_back(v);
        v = '{name: "sat_neg", a: fill(8'h20), b: fill(8'hE0), exp_c: fill(8'h80)}; vecs.push_back(v);
        v = '{name: "trunc", a: fill(8'h01), b: fill(8'h01), exp_c: fill(8'h00)};   vecs.push_back(v);
        v = '{name: "floor", a: fill(8'hFF), b: fill(8'h01), exp_c: fill(8'hFF)};   vecs.push_back(v);
        a = rand_mat();
        b = rand_mat();
        a[0][0] = 8'h08; a[0][1] = 8'hF8; a[0][2] = 8'h0C; a[0][3] = 8'h10;
        b[0][0] = 8'h14; b[1][0] = 8'h10; b[2][0] = 8'h0C; b[3][0] = 8'h08;
        v = '{name: "mixed", a: a, b: b, exp_c: model(a, b)};                  vecs.push_back(v);
        for (int r = 0; r < 3; r++) begin
            a = rand_mat();
            b = rand_mat();
            v = '{name: $sformatf("random%0d", r), a: a, b: b, exp_c: model(a, b)};
            vecs.push_back(v);
        end

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].a, vecs[n].b, vecs[n].exp_c);
            checkOutput(vecs[n].name);
        end

        // A start pulse with different data while the job streams is ignored.
        a  = rand_mat();
        b  = rand_mat();
        a2 = rand_mat();
        applyStimulus(a, b, model(a, b));
        repeat (2) @(negedge i_clk);
        i_a          = a2;
        i_b          = rand_mat();
        i_validInput = 1'b1;
        @(negedge i_clk);
        i_validInput = 1'b0;
        checkOutput("ignore_in_run");

        // Reset while the counter sits at N aborts the job without a pulse.
        applyStimulus(rand_mat(), rand_mat(), '0);
        repeat (N) @(negedge i_clk);
        i_arst = 1'b1;
        @(negedge i_clk);
        i_arst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        checkEqual("abort_o_c", 128'(o_c), 128'(0));
        checkEqual("abort_valid", 128'(o_validResult), 128'(0));
        repeat (3 * N + 4) @(negedge i_clk);
        checkEqual("abort_no_result", 128'(o_c), 128'(0));

        // Start held high: one job per entry into idle, back to back.
        a = rand_mat();
        b = rand_mat();
        @(negedge i_clk);
        i_a          = a;
        i_b          = b;
        i_validInput = 1'b1;
        exp_q.push_back(model(a, b));
        exp_cyc_q.push_back(cyc + 1 + 3 * N);
        exp_q.push_back(model(a, b));
        exp_cyc_q.push_back(cyc + 3 * N + 2 + 3 * N);
        repeat (3 * N + 2) @(negedge i_clk);
        i_validInput = 1'b0;
        checkOutput("held_start");

        // Jobs issued from idle right after each result.
        for (int r = 0; r < 2; r++) begin
            a = rand_mat();
            b = rand_mat();
            applyStimulus(a, b, model(a, b));
            checkOutput($sformatf("back_to_back%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
